// File: rtl/sram_access_sequencer.sv
// sram_access_sequencer: round-robin arbiter plus fixed strobe sequencer for an
// 8-bit SRAM whose read path runs through a hex inverter and a bus transceiver.
// Every transaction runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> RECOVER.
// All outputs are registered; the output decode looks at the *next* state so
// the strobes line up with the state the FSM is entering.
module sram_access_sequencer #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = 1,  // legal range 1..15
    parameter int INVERT_READ = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_cs_n,
    output logic          ram_we_n,
    input  logic [DW-1:0] bus_in,
    output logic          bt_oe_n,
    output logic          bt_dir,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RECOVER
    } state_t;

    // ACCESS counter is loaded with WAIT_CYCLES-1 and counts down to zero.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          own_q, own_d;     // 1 = requester 1 owns the transaction
    logic          last_q, last_d;   // 1 = requester 1 was served last
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] ram_a_q, ram_a_d;
    logic [DW-1:0] ram_d_q, ram_d_d;
    logic          ram_cs_n_q, ram_cs_n_d;
    logic          ram_we_n_q, ram_we_n_d;
    logic          bt_oe_n_q, bt_oe_n_d;
    logic          bt_dir_q, bt_dir_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic          gnt1;

    // Next-state logic: arbitration, transaction latch, ACCESS countdown, read capture.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        own_d   = own_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        gnt1    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // Requester 1 wins when alone, or when both ask and 0 went last.
                    gnt1    = req1 && (!req0 || !last_q);
                    own_d   = gnt1;
                    last_d  = gnt1;
                    we_d    = gnt1 ? we1 : we0;
                    addr_d  = gnt1 ? addr1 : addr0;
                    wdata_d = gnt1 ? wdata1 : wdata0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RECOVER;
                    // Last ACCESS cycle: RAM data has settled through the inverter.
                    if (!we_q) begin
                        rdata_d = (INVERT_READ != 0) ? ~bus_in : bus_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the state being entered, so registered strobes match it.
    always_comb begin
        ram_cs_n_d = 1'b1;
        ram_we_n_d = 1'b1;
        bt_oe_n_d  = 1'b1;
        bt_dir_d   = 1'b1;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        ram_a_d    = ram_a_q;
        ram_d_d    = ram_d_q;
        busy_d     = (state_d != ST_IDLE);
        case (state_d)
            ST_SETUP: begin
                ram_cs_n_d = 1'b0;
                ram_a_d    = addr_d;
                if (we_d) begin
                    ram_d_d  = wdata_d;
                    bt_dir_d = 1'b0;
                end
            end
            ST_ACCESS: begin
                ram_cs_n_d = 1'b0;
                if (we_d) begin
                    ram_we_n_d = 1'b0;
                    bt_dir_d   = 1'b0;
                end else begin
                    bt_oe_n_d = 1'b0;
                end
            end
            ST_RECOVER: begin
                // Chip select held one more cycle for address/data hold time.
                ram_cs_n_d = 1'b0;
                bt_dir_d   = !we_d;
                ack0_d     = !own_d;
                ack1_d     = own_d;
            end
            default: begin
            end
        endcase
    end

    // State and output registers; reset parks every strobe inactive at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            own_q      <= 1'b0;
            last_q     <= 1'b1;  // pretend requester 1 went last so req0 wins first
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ram_a_q    <= '0;
            ram_d_q    <= '0;
            ram_cs_n_q <= 1'b1;
            ram_we_n_q <= 1'b1;
            bt_oe_n_q  <= 1'b1;
            bt_dir_q   <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            own_q      <= own_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ram_a_q    <= ram_a_d;
            ram_d_q    <= ram_d_d;
            ram_cs_n_q <= ram_cs_n_d;
            ram_we_n_q <= ram_we_n_d;
            bt_oe_n_q  <= bt_oe_n_d;
            bt_dir_q   <= bt_dir_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata    = rdata_q;
    assign ram_a    = ram_a_q;
    assign ram_d    = ram_d_q;
    assign ram_cs_n = ram_cs_n_q;
    assign ram_we_n = ram_we_n_q;
    assign bt_oe_n  = bt_oe_n_q;
    assign bt_dir   = bt_dir_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Testbench for sram_access_sequencer. Three configurations run side by side:
// (WAIT_CYCLES, INVERT_READ) = (1,1), (3,1), (1,0). Each has an SRAM model that
// answers on bus_in, a transaction-level reference model that grants requests
// and pushes expected acks into a queue, and a monitor that pops on every ack.
module tb_sram_access_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    typedef struct {
        int         owner;
        int         due;
        logic       we;
        logic [7:0] addr;
        logic [7:0] rd;
    } exp_t;

    typedef struct {
        bit         valid;
        int         start;
        int         owner;
        logic       we;
        logic [7:0] addr;
    } txn_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int CFG = g;
        localparam int W   = (g == 1) ? 3 : 1;
        localparam int INV = (g == 2) ? 0 : 1;

        logic       rst = 1'b0;
        logic [1:0] req = 2'b00;
        logic [1:0] we  = 2'b00;
        logic [7:0] addr  [2];
        logic [7:0] wdata [2];
        logic       ack0, ack1, ram_cs_n, ram_we_n, bt_oe_n, bt_dir, busy;
        logic [7:0] rdata, ram_a, ram_d, bus_in;

        logic [7:0] env_mem   [256];  // the physical RAM
        logic [7:0] model_mem [256];  // reference model's view of memory

        // reference model state
        int         cyc = 0;
        int         next_free = 0;
        int         last_served = 1;
        logic [7:0] last_rd = 8'h00;
        logic [7:0] last_wd = 8'h00;
        logic [7:0] held = 8'h00;
        txn_t       cur;
        exp_t       exp_q [$];
        int         ack_log [$];

        sram_access_sequencer #(
            .AW(8), .DW(8), .WAIT_CYCLES(W), .INVERT_READ(INV)
        ) u_dut (
            .clk(clk), .rst(rst),
            .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
            .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
            .ack0(ack0), .ack1(ack1), .rdata(rdata),
            .ram_a(ram_a), .ram_d(ram_d), .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n),
            .bus_in(bus_in), .bt_oe_n(bt_oe_n), .bt_dir(bt_dir), .busy(busy)
        );

        // hex inverter present only when the design is told to undo it
        assign bus_in = (INV != 0) ? ~env_mem[ram_a] : env_mem[ram_a];

        function automatic string tag(input string s);
            return $sformatf("cfg%0d %s", CFG, s);
        endfunction

        task automatic model_reset();
            exp_q.delete();
            cur.valid   = 1'b0;
            last_served = 1;
            next_free   = 0;
            last_rd     = 8'h00;
            last_wd     = 8'h00;
            held        = 8'h00;
        endtask

        // Reference model: one transaction at a time, W+3 cycles apart at best,
        // round-robin between simultaneous requesters.
        initial begin : model
            forever begin
                @(posedge clk);
                cyc++;
                if (!rst && cyc >= next_free && req != 2'b00) begin : grant
                    int   w;
                    exp_t e;
                    if (req[0] && req[1]) w = (last_served == 0) ? 1 : 0;
                    else                  w = req[1] ? 1 : 0;
                    last_served = w;
                    e.owner = w;
                    e.due   = cyc + W + 1;
                    e.we    = we[w];
                    e.addr  = addr[w];
                    if (we[w]) begin
                        model_mem[addr[w]] = wdata[w];
                        last_wd = wdata[w];
                        e.rd    = last_rd;
                    end else begin
                        e.rd    = model_mem[addr[w]];
                        last_rd = e.rd;
                    end
                    exp_q.push_back(e);
                    cur.valid = 1'b1;
                    cur.start = cyc;
                    cur.owner = w;
                    cur.we    = we[w];
                    cur.addr  = addr[w];
                    next_free = cyc + W + 3;
                end
            end
        end

        // Monitor: RAM write capture, scoreboard on acks, cycle-by-cycle strobes.
        initial begin : monitor
            forever begin : mon_cycle
                int         off;
                bit         in_t, acc;
                logic [30:0] exp_v;
                exp_t       e;
                @(negedge clk);
                if (!ram_cs_n && !ram_we_n) env_mem[ram_a] = ram_d;
                if (rst) continue;
                check(tag("exclusive"), {ack0 & ack1, ~ram_we_n & ~bt_oe_n, ~ram_we_n & ram_cs_n}, 3'b000);
                if (ack0 || ack1) begin
                    if (exp_q.size() == 0) begin
                        check(tag("unexpected_ack"), {ack1, ack0}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        check(tag("ack_owner"), {ack1, ack0}, (e.owner == 1) ? 2'b10 : 2'b01);
                        check(tag("ack_cycle"), cyc, e.due);
                        if (!e.we) check(tag("rdata"), rdata, e.rd);
                        held = e.rd;
                        ack_log.push_back(ack1 ? 1 : 0);
                    end
                end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
                    e = exp_q.pop_front();
                    check(tag("missing_ack"), {ack1, ack0}, (e.owner == 1) ? 2'b10 : 2'b01);
                end
                off  = cyc - cur.start;
                in_t = cur.valid && off <= W + 1;
                acc  = in_t && off >= 1 && off <= W;
                exp_v = {in_t, !in_t, !(acc && cur.we), !(acc && !cur.we), !(in_t && cur.we),
                         in_t && off == W + 1 && cur.owner == 0,
                         in_t && off == W + 1 && cur.owner == 1,
                         held, cur.valid ? cur.addr : 8'h00, last_wd};
                check(tag("outputs"), {busy, ram_cs_n, ram_we_n, bt_oe_n, bt_dir, ack0, ack1,
                                       rdata, ram_a, ram_d}, exp_v);
            end
        end

        // One requester: mode 0 directed write/read, 1 incrementing reads,
        // 2 back-to-back random, 3 random with gaps and input scrambling,
        // 4 drop req right after it is taken.
        task automatic run_req(input int r, input int n, input int mode);
            int raise_cyc, last_ack;
            bit got;
            last_ack = 0;
            for (int i = 0; i < n; i++) begin
                case (mode)
                    0: begin we[r] = (i == 0); addr[r] = 8'h3C; wdata[r] = 8'hA5; end
                    1: begin we[r] = 1'b0; addr[r] = 8'h40 + 8'(i); wdata[r] = 8'($urandom); end
                    default: begin
                        we[r] = 1'($urandom_range(0, 1)); addr[r] = 8'($urandom); wdata[r] = 8'($urandom);
                    end
                endcase
                req[r]    = 1'b1;
                raise_cyc = cyc;
                got       = 1'b0;
                for (int c = 0; c < 64 && !got; c++) begin
                    @(negedge clk);
                    if (mode == 4) req[r] = 1'b0;
                    if ((r == 0) ? ack0 : ack1) begin
                        got = 1'b1;
                    end else if (mode == 3 && $urandom_range(0, 1) == 1) begin
                        we[r] = 1'($urandom_range(0, 1)); addr[r] = 8'($urandom); wdata[r] = 8'($urandom);
                    end
                end
                check(tag($sformatf("ack_seen r%0d", r)), got, 1'b1);
                if (mode <= 1) begin
                    if (i == 0) check(tag("latency"), cyc - raise_cyc, W + 2);
                    else        check(tag("b2b_spacing"), cyc - last_ack, W + 3);
                end
                last_ack = cyc;
                if (i == n - 1 || mode == 4 || (mode == 3 && $urandom_range(0, 2) == 0)) begin
                    req[r] = 1'b0;
                    repeat ((mode == 4) ? 2 : $urandom_range(0, 3)) @(negedge clk);
                end
            end
            req[r] = 1'b0;
        endtask

        task automatic do_reset();
            @(negedge clk);
            #2 rst = 1'b1;
            model_reset();
            repeat (2) @(negedge clk);
            #2 rst = 1'b0;
            @(negedge clk);
        endtask

        initial begin : stimulus
            logic [7:0] a;
            bit         got;
            addr[0] = 8'h00; addr[1] = 8'h00; wdata[0] = 8'h00; wdata[1] = 8'h00;
            for (int i = 0; i < 256; i++) begin
                a = 8'($urandom);
                env_mem[i] = a;
                model_mem[i] = a;
            end
            cur.valid = 1'b0;
            cur.start = 0;
            cur.owner = 0;
            cur.we    = 1'b0;
            cur.addr  = 8'h00;
            #1 rst = 1'b1;
            model_reset();
            #1;
            check(tag("reset_values"), {busy, ram_cs_n, ram_we_n, bt_oe_n, bt_dir, ack0, ack1,
                                        rdata, ram_a, ram_d}, {7'b0111100, 24'h000000});
            @(negedge clk);
            #2 rst = 1'b0;
            @(negedge clk);

            run_req(0, 2, 0);           // write 0x3C=0xA5, read it back
            repeat (2) @(negedge clk);
            run_req(1, 4, 1);           // four back-to-back reads
            do_reset();

            ack_log.delete();
            fork
                run_req(0, 4, 2);
                run_req(1, 4, 2);
            join
            check(tag("contention_count"), ack_log.size(), 8);
            for (int i = 0; i < ack_log.size(); i++)
                check(tag($sformatf("contention_grant%0d", i)), ack_log[i], i % 2);

            fork
                run_req(0, 30, 3);
                run_req(1, 30, 3);
            join
            repeat (2) @(negedge clk);

            // Reset in the middle of a write's ACCESS phase.
            a = 8'($urandom);
            we[0] = 1'b1; addr[0] = a; wdata[0] = model_mem[a]; req[0] = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (!ram_we_n) got = 1'b1;
            end
            check(tag("write_strobe_seen"), got, 1'b1);
            req[0] = 1'b0;
            #2 rst = 1'b1;
            model_reset();
            #1;
            check(tag("async_reset"), {ram_cs_n, ram_we_n, bt_oe_n, ack0, ack1, busy}, 6'b111000);
            repeat (2) @(negedge clk);
            #2 rst = 1'b0;
            @(negedge clk);
            check(tag("busy_after_reset"), busy, 1'b0);
            repeat (3) @(negedge clk);

            run_req(0, 3, 4);           // req dropped after being taken still gets ack
            run_req(1, 2, 2);
            repeat (4) @(negedge clk);
            check(tag("scoreboard_empty"), exp_q.size(), 0);
            n_done++;
        end
    end

    initial begin : top
        bit all_done;
        all_done = 1'b0;
        for (int c = 0; c < 20000 && !all_done; c++) begin
            @(negedge clk);
            if (n_done == 3) all_done = 1'b1;
        end
        checks++;
        if (!all_done) begin
            errors++;
            $display("FAIL run_timeout: actual %0d configs done required 3", n_done);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
